// File: rtl/serial_adder_ctrl_if.sv
// Handshake bundle for the bit-serial add sequencer: operand side, result side
// and the status outputs.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    localparam int IDX_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             busy;
    logic [IDX_W-1:0] bit_idx;

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, busy, bit_idx
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, busy, bit_idx
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full-add cell walks the operands LSB-first,
// one bit per clock, with the carry held in a register between bits.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// RUN   | adding bit cnt, WIDTH cycles in total
// DONE  | result presented, held until out_ready
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    serial_adder_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(WIDTH);

    if (WIDTH < 2 || WIDTH > 64) begin : g_width_chk
        $error("serial_adder_ctrl: WIDTH must be in 2..64");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             cout_q;
    logic             valid_q;
    logic             busy_q;
    logic [IDX_W-1:0] cnt;

    logic h1_s, h1_c, h2_s, h2_c, c_next;

    // Full add as two cascaded half adds plus an OR of their carries.
    always_comb begin
        h1_s   = a_sh[0] ^ b_sh[0];
        h1_c   = a_sh[0] & b_sh[0];
        h2_s   = h1_s ^ carry;
        h2_c   = h1_s & carry;
        c_next = h1_c | h2_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            res     <= '0;
            carry   <= 1'b0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh   <= bus.in_a;
                        b_sh   <= bus.in_b;
                        carry  <= bus.in_cin;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    res   <= {h2_s, res[WIDTH-1:1]};
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= c_next;
                    if (cnt == LAST_IDX) begin
                        // cnt returns to 0 so bit_idx reads 0 outside RUN
                        cnt     <= '0;
                        cout_q  <= c_next;
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // in_ready must drop immediately with rst, so it is not a flop.
    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = valid_q;
    assign bus.out_sum   = res;
    assign bus.out_cout  = cout_q;
    assign bus.busy      = busy_q;
    assign bus.bit_idx   = cnt;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: reference sums go into a scoreboard
// queue at each accept and are checked when the result handshake fires.
module tb_serial_adder_ctrl;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst;

    serial_adder_ctrl_if #(.WIDTH(WIDTH)) ifc ();

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic [WIDTH:0] sb[$];
    int acc_cyc[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: note handshakes visible before the edge, then sample 1 ns after it.
    task automatic tick(output logic acc);
        logic           hs;
        logic [WIDTH:0] got;
        acc = ifc.in_valid && ifc.in_ready;
        hs  = ifc.out_valid && ifc.out_ready;
        got = {ifc.out_cout, ifc.out_sum};
        if (acc) begin
            sb.push_back({1'b0, ifc.in_a} + {1'b0, ifc.in_b} + (WIDTH+1)'(ifc.in_cin));
            acc_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (hs) begin
            chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) chk("result", 64'(got), 64'(sb.pop_front()));
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
        logic acc;
        ifc.in_a = a; ifc.in_b = b; ifc.in_cin = cin; ifc.in_valid = 1'b1;
        tick(acc);
        chk("accept", 64'(acc), 64'd1);
        ifc.in_valid = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            chk("run_out_valid", 64'(ifc.out_valid), 64'd0);
            chk("run_busy", 64'(ifc.busy), 64'd1);
            chk("run_bit_idx", 64'(ifc.bit_idx), 64'(i));
            tick(acc);
        end
        chk("latency_out_valid", 64'(ifc.out_valid), 64'd1);
        chk("done_in_ready", 64'(ifc.in_ready), 64'd0);
    endtask

    task automatic drain();
        logic acc;
        ifc.out_ready = 1'b1;
        tick(acc);
        ifc.out_ready = 1'b0;
        chk("drain_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("drain_busy", 64'(ifc.busy), 64'd0);
        chk("drain_sb_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic acc;
        int   n_acc;
        int   budget;

        rst = 1'b1;
        ifc.in_valid = 1'b0; ifc.in_a = '0; ifc.in_b = '0; ifc.in_cin = 1'b0;
        ifc.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(ifc.in_ready), 64'd0);
        chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("rst_busy", 64'(ifc.busy), 64'd0);
        chk("rst_bit_idx", 64'(ifc.bit_idx), 64'd0);
        chk("rst_out_sum", 64'(ifc.out_sum), 64'd0);
        chk("rst_out_cout", 64'(ifc.out_cout), 64'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 64'(ifc.in_ready), 64'd1);

        run_op(8'h3C, 8'h55, 1'b0);
        chk("sum_3c_55", 64'(ifc.out_sum), 64'h91);
        chk("cout_3c_55", 64'(ifc.out_cout), 64'd0);
        drain();

        run_op(8'hFF, 8'h01, 1'b0);
        chk("sum_ff_01", 64'(ifc.out_sum), 64'h00);
        chk("cout_ff_01", 64'(ifc.out_cout), 64'd1);
        drain();

        run_op(8'hFF, 8'h00, 1'b1);
        chk("sum_ff_00_c1", 64'(ifc.out_sum), 64'h00);
        chk("cout_ff_00_c1", 64'(ifc.out_cout), 64'd1);
        drain();

        run_op(8'hFF, 8'h00, 1'b0);
        chk("sum_ff_00_c0", 64'(ifc.out_sum), 64'hFF);
        chk("cout_ff_00_c0", 64'(ifc.out_cout), 64'd0);
        drain();

        // Backpressure with new operands waiting.
        run_op(8'h12, 8'h34, 1'b1);
        ifc.in_a = 8'h77; ifc.in_b = 8'h11; ifc.in_cin = 1'b0; ifc.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(acc);
            chk("bp_no_accept", 64'(acc), 64'd0);
            chk("bp_out_valid", 64'(ifc.out_valid), 64'd1);
            chk("bp_out_sum", 64'(ifc.out_sum), 64'h47);
            chk("bp_out_cout", 64'(ifc.out_cout), 64'd0);
            chk("bp_in_ready", 64'(ifc.in_ready), 64'd0);
        end
        ifc.out_ready = 1'b1;
        tick(acc);
        chk("bp_release_no_accept", 64'(acc), 64'd0);
        ifc.out_ready = 1'b0;
        chk("bp_idle_in_ready", 64'(ifc.in_ready), 64'd1);
        chk("bp_idle_out_valid", 64'(ifc.out_valid), 64'd0);
        tick(acc);
        chk("bp_next_accept", 64'(acc), 64'd1);
        ifc.in_valid = 1'b0;
        chk("bp_next_busy", 64'(ifc.busy), 64'd1);
        budget = 0;
        while (!ifc.out_valid && budget < 20) begin
            tick(acc);
            budget++;
        end
        chk("bp_next_valid_in_time", 64'(ifc.out_valid), 64'd1);
        chk("bp_next_sum", 64'(ifc.out_sum), 64'h88);
        drain();

        // Reset in the middle of RUN.
        ifc.in_a = 8'hAA; ifc.in_b = 8'h55; ifc.in_cin = 1'b0; ifc.in_valid = 1'b1;
        tick(acc);
        ifc.in_valid = 1'b0;
        repeat (3) tick(acc);
        chk("mid_bit_idx", 64'(ifc.bit_idx), 64'd3);
        rst = 1'b1;
        #1;
        sb.delete();
        chk("mid_rst_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("mid_rst_busy", 64'(ifc.busy), 64'd0);
        chk("mid_rst_bit_idx", 64'(ifc.bit_idx), 64'd0);
        chk("mid_rst_in_ready", 64'(ifc.in_ready), 64'd0);
        tick(acc);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(ifc.in_ready), 64'd1);
        chk("post_rst_out_valid", 64'(ifc.out_valid), 64'd0);
        run_op(8'h01, 8'h01, 1'b0);
        chk("sum_01_01", 64'(ifc.out_sum), 64'h02);
        chk("cout_01_01", 64'(ifc.out_cout), 64'd0);
        drain();

        // Streaming: in_valid and out_ready held high.
        acc_cyc.delete();
        ifc.out_ready = 1'b1;
        ifc.in_a = 8'($urandom); ifc.in_b = 8'($urandom); ifc.in_cin = 1'($urandom);
        ifc.in_valid = 1'b1;
        n_acc = 0;
        budget = 0;
        while (n_acc < 4 && budget < 100) begin
            tick(acc);
            budget++;
            if (acc) begin
                n_acc++;
                ifc.in_a = 8'($urandom); ifc.in_b = 8'($urandom); ifc.in_cin = 1'($urandom);
            end
        end
        ifc.in_valid = 1'b0;
        chk("stream_accepts", 64'(n_acc), 64'd4);
        budget = 0;
        while (sb.size() != 0 && budget < 30) begin
            tick(acc);
            budget++;
        end
        chk("stream_sb_drained", 64'(sb.size()), 64'd0);
        for (int i = 1; i < acc_cyc.size(); i++)
            chk("stream_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(WIDTH + 2));
        ifc.out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
